bitcol_encoder_bitwave: RTL and testbench
=========================================

# bitcol_encoder_bitwave

Bit-column encoder that produces the per-group column mask and the compressed bit-column stream consumed by the Bitwave scheduler and PE array. It accepts one group of `VEC_LENGTH` two's-complement weights and converts each to sign-magnitude. It then emits, one per cycle under valid/ready backpressure, only the non-zero bit columns, each tagged with its column index. The block sits between the weight buffer and the compute-side register files.

## Interface
- `DATA_WIDTH`, 8: weight width; bit `DATA_WIDTH-1` is the sign column.
- `VEC_LENGTH`, 8: weights per group, which is also the bit-column width.
- `SEL_WIDTH`, `$clog2(DATA_WIDTH)`: column index width.
- `CNT_WIDTH`, `$clog2(DATA_WIDTH+1)`: non-zero column count width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  weight group present.
- `in_ready`  out  1  encoder can accept a group.
- `in_weight`  in  `VEC_LENGTH`x`DATA_WIDTH`  group, two's complement.
- `out_valid`  out  1  column beat present.
- `out_ready`  in  1  consumer takes beat.
- `out_col_mask`  out  `DATA_WIDTH`  per-column non-zero flag; stable for the whole group.
- `out_nz_col_num`  out  `CNT_WIDTH`  popcount of `out_col_mask`; stable for the whole group.
- `out_col_data`  out  `VEC_LENGTH`  bit column; bit *i* belongs to lane *i*.
- `out_col_idx`  out  `SEL_WIDTH`  column index of the beat.
- `out_last`  out  1  final beat of the group.
- `out_empty`  out  1  group has no streamed columns.

## Operation
- **Conversion:** sign = weight MSB; magnitude = |w| over `DATA_WIDTH-1` bits. Most-negative input saturates to magnitude all-ones (-128 becomes 127).
- **Column mask:** `col_mask[j]` = OR over lanes of magnitude bit *j*, for *j* < `DATA_WIDTH-1`. `col_mask[DATA_WIDTH-1]` = OR of the signs.
- **Count:** `out_nz_col_num` = popcount of all `DATA_WIDTH` mask bits, sign bit included.
- **State machine:** two states, IDLE and STREAM.
  - IDLE: on `in_valid & in_ready`, register the sign-magnitude group, mask and count, and load the pending-column register. Go to STREAM.
  - STREAM: the beat shows the lowest-index set bit of the pending register. On `out_valid & out_ready` that bit is cleared.
  - STREAM: the beat whose pending register has one bit left asserts `out_last`. Accepting it returns the FSM to IDLE.
- **Empty group:** when no streamed column is set, exactly one beat is sent with `out_col_data`=0, `out_col_idx`=0, `out_empty`=1 and `out_last`=1.
- **Back-to-back:** `in_ready` = IDLE | (`out_valid & out_ready & out_last`). A simultaneous last-beat accept and new-group accept loads the new group and stays in STREAM.
- **Backpressure:** while `out_valid & ~out_ready`, every `out_*` signal holds stable.

## Timing
- **Reset:** `out_valid`, `out_col_mask`, `out_nz_col_num`, `out_col_data`, `out_col_idx`, `out_last` and `out_empty` are all 0. The FSM resets to IDLE.
- **Ready during reset:** `in_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- **Mid-group reset:** asserting reset during STREAM drops `out_valid` asynchronously and discards the group.
- **Latency:** a group accepted at edge *t* gives `out_valid` high after edge *t*, with the first beat in cycle *t+1*.
- **Occupancy:** a group with *k* streamed columns occupies max(*k*,1) cycles when `out_ready` stays high.
- **Throughput:** with continuous input, one group per max(*k*,1) cycles, with no bubble.
- All outputs are registered or decoded from registered state only. Inputs do not reach outputs combinationally, except that `in_ready` depends on `out_ready`.

## Configuration
- **`BITWAVE_SIGN_COL_EN` defined:** the sign column (index `DATA_WIDTH-1`) is part of the pending register. It is streamed as the final beat when set, with `out_col_data` = lane signs.
- **`BITWAVE_SIGN_COL_EN` undefined:** only magnitude columns are streamed. The sign appears only in `out_col_mask[DATA_WIDTH-1]`, and `out_nz_col_num` is unchanged.

## Structure
- **`bitwave_pkg`** holds:
  - default `DATA_WIDTH` and `VEC_LENGTH`;
  - the state enum `{IDLE, STREAM}`;
  - the helper function for the lowest-set-bit index.
- **`tc_to_sm`** is the one sub-module: a per-lane two's-complement to sign-magnitude converter with saturation, instantiated `VEC_LENGTH` times through generate.

## Test plan
All scenarios use `VEC_LENGTH`=4 and `DATA_WIDTH`=8.
- **Small positives:** {3,1,0,0} -> mask 8'h03, count 2. Beats are idx0 data 4'b0011, then idx1 data 4'b0001 with `out_last`.
- **All zero:** {0,0,0,0} -> one beat with `out_empty`=1, `out_last`=1, mask 0, count 0. The next group is accepted on that beat.
- **Sign column:** {-5,0,0,0} -> mask 8'h85, count 3.
  - Macro off: beats idx0 and idx2, each with data 4'b0001.
  - Macro on: a third beat idx7 with data 4'b0001 and `out_last`.
- **Saturation:** {-128,0,0,0} -> mask 8'hFF, count 8. Beats are idx0..6 with data 4'b0001 (idx7 added when the macro is on).
- **Backpressure and back-to-back:** `out_ready` low for 3 cycles on the second beat -> all outputs held. Then `in_valid` presented with the last beat -> new group's first beat appears the next cycle, with no bubble.
- **Mid-group reset:** reset asserted during beat 2 -> `out_valid` goes 0 immediately and `in_ready` is 1 after release. A fresh group then streams correctly.

Source files
------------

// File: rtl/bitcol_encoder_bitwave_pkg.sv
// Shared defaults, FSM state type and bit-scan helpers for the Bitwave bit-column encoder.
package bitwave_pkg;

  localparam int BW_DATA_WIDTH = 8;
  localparam int BW_VEC_LENGTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } bw_state_e;

  // Index of the lowest set bit; an all-zero vector maps to index 0.
  function automatic int unsigned lowest_set_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 32'd0;
    for (int k = 31; k >= 0; k--) begin
      if (v[k]) begin
        idx = k;
      end
    end
    return idx;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 32'd0;
    for (int k = 0; k < 32; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bitcol_encoder_bitwave_if.sv
// Weight-group input and bit-column output handshake bundle of the encoder.
interface bitcol_encoder_bitwave_if
  import bitwave_pkg::*;
#(
  parameter int DATA_WIDTH = BW_DATA_WIDTH,
  parameter int VEC_LENGTH = BW_VEC_LENGTH,
  parameter int SEL_WIDTH  = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_weight;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0]                out_col_mask;
  logic [CNT_WIDTH-1:0]                 out_nz_col_num;
  logic [VEC_LENGTH-1:0]                out_col_data;
  logic [SEL_WIDTH-1:0]                 out_col_idx;
  logic                                 out_last;
  logic                                 out_empty;

  modport master (
    output in_valid, in_weight, out_ready,
    input  in_ready, out_valid, out_col_mask, out_nz_col_num,
           out_col_data, out_col_idx, out_last, out_empty
  );

  modport slave (
    input  in_valid, in_weight, out_ready,
    output in_ready, out_valid, out_col_mask, out_nz_col_num,
           out_col_data, out_col_idx, out_last, out_empty
  );
endinterface

// File: rtl/bitcol_encoder_bitwave_tc_to_sm.sv
// Per-lane two's-complement to sign-magnitude converter; the most negative value saturates.
module tc_to_sm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] w_i,
  output logic                  sign_o,
  output logic [DATA_WIDTH-2:0] mag_o
);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-2:0] ONE_M    = {{(DATA_WIDTH-2){1'b0}}, 1'b1};

  logic [DATA_WIDTH-2:0] neg_s;

  // Negation only needs the magnitude bits; the lost MSB is exactly the saturation case.
  always_comb begin
    neg_s  = (~w_i[DATA_WIDTH-2:0]) + ONE_M;
    sign_o = w_i[DATA_WIDTH-1];
    if (w_i == MOST_NEG) begin
      mag_o = '1;
    end else if (w_i[DATA_WIDTH-1]) begin
      mag_o = neg_s;
    end else begin
      mag_o = w_i[DATA_WIDTH-2:0];
    end
  end
endmodule

// File: rtl/bitcol_encoder_bitwave.sv
// Bitwave bit-column encoder: streams the non-zero sign-magnitude columns of a weight group.
// Define BITWAVE_SIGN_COL_EN to also stream the sign column as the final beat.
module bitcol_encoder_bitwave
  import bitwave_pkg::*;
#(
  parameter int DATA_WIDTH = BW_DATA_WIDTH,
  parameter int VEC_LENGTH = BW_VEC_LENGTH,
  parameter int SEL_WIDTH  = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input logic                    clk,
  input logic                    reset,
  bitcol_encoder_bitwave_if.slave bus
);
`ifdef BITWAVE_SIGN_COL_EN
  localparam logic [DATA_WIDTH-1:0] STREAM_MASK = {DATA_WIDTH{1'b1}};
`else
  localparam logic [DATA_WIDTH-1:0] STREAM_MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
  localparam logic [DATA_WIDTH-1:0] ONE_W = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  bw_state_e                             state_q, state_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] sm_q, sm_d;
  logic [DATA_WIDTH-1:0]                 mask_q, mask_d, pend_q, pend_d, mask_s;
  logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d, cnt_s;
  logic [VEC_LENGTH-1:0]                 sign_s, col_s;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-2:0] mag_s;
  logic [SEL_WIDTH-1:0]                  idx_s;
  logic                                  valid_s, last_s, empty_s;
  logic                                  beat_fire_s, in_ready_s, in_fire_s;

  for (genvar g = 0; g < VEC_LENGTH; g++) begin : g_lane
    tc_to_sm #(.DATA_WIDTH(DATA_WIDTH)) u_tc_to_sm (
      .w_i    (bus.in_weight[g]),
      .sign_o (sign_s[g]),
      .mag_o  (mag_s[g])
    );
  end

  // Column mask and population count of the incoming group.
  always_comb begin
    mask_s = '0;
    for (int j = 0; j < DATA_WIDTH - 1; j++) begin
      for (int i = 0; i < VEC_LENGTH; i++) begin
        mask_s[j] = mask_s[j] | mag_s[i][j];
      end
    end
    mask_s[DATA_WIDTH-1] = |sign_s;
    cnt_s = CNT_WIDTH'(popcount(32'(mask_s)));
  end

  // Beat decode from the registered group and pending-column set.
  always_comb begin
    valid_s = (state_q == STREAM);
    idx_s   = SEL_WIDTH'(lowest_set_idx(32'(pend_q)));
    for (int i = 0; i < VEC_LENGTH; i++) begin
      col_s[i] = valid_s & sm_q[i][idx_s];
    end
    last_s      = valid_s & ((pend_q & (pend_q - ONE_W)) == '0);
    empty_s     = valid_s & (pend_q == '0);
    beat_fire_s = valid_s & bus.out_ready;
    in_ready_s  = ~reset & ((state_q == IDLE) | (beat_fire_s & last_s));
    in_fire_s   = bus.in_valid & in_ready_s;
  end

  // Next-state: load on input accept, otherwise retire one column per accepted beat.
  always_comb begin
    state_d = state_q;
    sm_d    = sm_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (in_fire_s) begin
      state_d = STREAM;
      for (int i = 0; i < VEC_LENGTH; i++) begin
        sm_d[i] = {sign_s[i], mag_s[i]};
      end
      mask_d = mask_s;
      cnt_d  = cnt_s;
      pend_d = mask_s & STREAM_MASK;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        STREAM: begin
          if (beat_fire_s & last_s) begin
            state_d = IDLE;
            pend_d  = '0;
          end else if (beat_fire_s) begin
            pend_d = pend_q & (pend_q - ONE_W);
          end else begin
            pend_d = pend_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Group registers; reset discards any group in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sm_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sm_q    <= sm_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = valid_s;
  assign bus.out_col_mask   = mask_q;
  assign bus.out_nz_col_num = cnt_q;
  assign bus.out_col_data   = col_s;
  assign bus.out_col_idx    = idx_s;
  assign bus.out_last       = last_s;
  assign bus.out_empty      = empty_s;
endmodule

// File: tb/tb_bitcol_encoder_bitwave.sv
// Self-checking bench for bitcol_encoder_bitwave (VEC_LENGTH=4, DATA_WIDTH=8) with a beat-queue model.
module tb_bitcol_encoder_bitwave;
  localparam int DW = 8;
  localparam int VL = 4;

  typedef struct {
    logic [VL-1:0] data;
    logic [2:0]    idx;
    logic          last;
    logic          empty;
    logic [DW-1:0] mask;
    logic [3:0]    cnt;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    tests = 0;
  int    fails = 0;
  beat_t q[$];

  bitcol_encoder_bitwave_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) bus ();

  bitcol_encoder_bitwave #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: sign-magnitude with clamp, then list every non-zero streamed column.
  task automatic push_group(input int a, input int b, input int c, input int d);
    int    w[VL];
    int    mag[VL];
    bit    sg[VL];
    int    cols[$];
    int    cnt;
    logic [DW-1:0] mask;
    beat_t bt;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    mask = '0;
    for (int i = 0; i < VL; i++) begin
      sg[i]  = (w[i] < 0);
      mag[i] = (w[i] < 0) ? -w[i] : w[i];
      if (mag[i] > 127) mag[i] = 127;
      if (sg[i]) mask[DW-1] = 1'b1;
      for (int j = 0; j < DW - 1; j++)
        if (((mag[i] >> j) & 1) == 1) mask[j] = 1'b1;
    end
    cnt = 0;
    for (int j = 0; j < DW; j++) if (mask[j]) cnt++;
    for (int j = 0; j < DW - 1; j++) if (mask[j]) cols.push_back(j);
`ifdef BITWAVE_SIGN_COL_EN
    if (mask[DW-1]) cols.push_back(DW - 1);
`endif
    bt.mask = mask;
    bt.cnt  = 4'(cnt);
    if (cols.size() == 0) begin
      bt.data = '0; bt.idx = 3'd0; bt.last = 1'b1; bt.empty = 1'b1;
      q.push_back(bt);
    end else begin
      foreach (cols[k]) begin
        for (int i = 0; i < VL; i++)
          bt.data[i] = (cols[k] == DW - 1) ? sg[i] : 1'(((mag[i] >> cols[k]) & 1));
        bt.idx   = 3'(cols[k]);
        bt.last  = (k == cols.size() - 1);
        bt.empty = 1'b0;
        q.push_back(bt);
      end
    end
  endtask

  // One clock: drive at negedge, check the visible beat, then advance the model at the edge.
  task automatic cyc(input bit iv, input int a, input int b, input int c, input int d, input bit ordy);
    bit exp_ready;
    bus.in_valid     = iv;
    bus.in_weight[0] = 8'(a);
    bus.in_weight[1] = 8'(b);
    bus.in_weight[2] = 8'(c);
    bus.in_weight[3] = 8'(d);
    bus.out_ready    = ordy;
    #1;
    exp_ready = (q.size() == 0) || (q[0].last && ordy);
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("col_data", bus.out_col_data, q[0].data);
      check("col_idx", bus.out_col_idx, q[0].idx);
      check("last", bus.out_last, q[0].last);
      check("empty", bus.out_empty, q[0].empty);
      check("col_mask", bus.out_col_mask, q[0].mask);
      check("nz_col_num", bus.out_nz_col_num, q[0].cnt);
    end
    @(posedge clk);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (iv && exp_ready) push_group(a, b, c, d);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cyc(1'b0, 0, 0, 0, 0, 1'b1);
      guard++;
    end
    check("drain_bound", q.size(), 0);
  endtask

  function automatic int rand_w();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return $urandom_range(0, 7);
      2: return int'($urandom_range(0, 255)) - 128;
      default: return -128;
    endcase
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_weight = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_col_mask", bus.out_col_mask, 0);
    check("rst_nz_col_num", bus.out_nz_col_num, 0);
    check("rst_col_data", bus.out_col_data, 0);
    check("rst_col_idx", bus.out_col_idx, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_empty", bus.out_empty, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);

    // Small positives.
    cyc(1'b1, 3, 1, 0, 0, 1'b1);
    check("pos_mask", bus.out_col_mask, 8'h03);
    check("pos_cnt", bus.out_nz_col_num, 4'd2);
    drain();

    // All-zero group, then back-to-back sign-column group on its single beat.
    cyc(1'b1, 0, 0, 0, 0, 1'b1);
    check("zero_empty", bus.out_empty, 1);
    check("zero_mask", bus.out_col_mask, 8'h00);
    cyc(1'b1, -5, 0, 0, 0, 1'b1);
    check("sign_mask", bus.out_col_mask, 8'h85);
    check("sign_cnt", bus.out_nz_col_num, 4'd3);
    drain();

    // Saturation.
    cyc(1'b1, -128, 0, 0, 0, 1'b1);
    check("sat_mask", bus.out_col_mask, 8'hFF);
    check("sat_cnt", bus.out_nz_col_num, 4'd8);
    drain();

    // Backpressure on beat 2, then a new group presented with the last beat.
    cyc(1'b1, 5, 2, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b1, 6, 0, 1, 0, 1'b1);
    check("b2b_no_bubble", bus.out_valid, 1);
    drain();

    // Mid-group reset during beat 2.
    cyc(1'b1, -128, 3, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_ready", bus.in_ready, 1);
    check("mid_rel_mask", bus.out_col_mask, 0);
    cyc(1'b1, 7, -1, 0, 64, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_w(), rand_w(),
          ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
